// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of the IF/DP requester handshakes and the unified memory port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if;
  // Instruction fetch port (read-only)
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  // Load/store data port
  logic        dp_req;
  logic        dp_we;
  logic [31:0] dp_addr;
  logic [31:0] dp_wdata;
  logic        dp_ack;
  logic [31:0] dp_rdata;
  logic        err;
  // Memory side
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_rdata,
    output if_ack, if_rdata, dp_ack, dp_rdata, err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  // Requester / memory-model view
  modport master (
    output if_req, if_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_rdata,
    input  if_ack, if_rdata, dp_ack, dp_rdata, err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin sharing of the unified big-endian memory between instruction
// fetch and the load/store port, with fixed-length access windows and
// rejection of misaligned or out-of-range word accesses.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES     = 128,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Highest byte address at which a full word still fits in memory
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  CNT_INIT  = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic        prio_dp_q, prio_dp_d;     // 1: DP wins the next tie
  logic        port_dp_q, port_dp_d;     // granted port, 1 = DP
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dp_rdata_q, dp_rdata_d;

  logic        w_gnt_dp;
  logic        w_gnt_if;
  logic [31:0] w_req_addr;
  logic        w_req_we;
  logic        w_req_bad;

  // Grant selection and legality check of the request that would be granted
  assign w_gnt_dp   = bus.dp_req & (~bus.if_req | prio_dp_q);
  assign w_gnt_if   = bus.if_req & ~w_gnt_dp;
  assign w_req_addr = w_gnt_dp ? bus.dp_addr : bus.if_addr;
  assign w_req_we   = w_gnt_dp & bus.dp_we;
  assign w_req_bad  = (w_req_addr[1:0] != 2'b00) || (w_req_addr > LAST_WORD);

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_dp_q   <= 1'b1;
      port_dp_q   <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dp_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      prio_dp_q   <= prio_dp_d;
      port_dp_q   <= port_dp_d;
      we_q        <= we_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dp_rdata_q  <= dp_rdata_d;
    end
  end

  // Next-state logic: grant in IDLE, count the access window, respond once
  always_comb begin
    state_d     = state_q;
    prio_dp_d   = prio_dp_q;
    port_dp_d   = port_dp_q;
    we_d        = we_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dp_rdata_d  = dp_rdata_q;

    case (state_q)
      IDLE: begin
        if (w_gnt_dp || w_gnt_if) begin
          port_dp_d = w_gnt_dp;
          prio_dp_d = w_gnt_if;          // loser of this grant wins next tie
          we_d      = w_req_we;
          err_d     = w_req_bad;
          if (w_req_bad) begin
            // Rejected requests never drive the memory address or strobes
            state_d = RESP;
          end else begin
            state_d    = ACCESS;
            cnt_d      = CNT_INIT;
            mem_addr_d = w_req_addr;
            if (w_gnt_dp) begin
              mem_wdata_d = bus.dp_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (port_dp_q) begin
              dp_rdata_d = bus.mem_rdata;
            end else begin
              if_rdata_d = bus.mem_rdata;
            end
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_rd    = (state_q == ACCESS) & ~we_q;
  assign bus.mem_wr    = (state_q == ACCESS) &  we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = (state_q == RESP) & ~port_dp_q;
  assign bus.dp_ack    = (state_q == RESP) &  port_dp_q;
  assign bus.err       = (state_q == RESP) &  err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dp_rdata  = dp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench for mem_port_arbiter with a byte-array memory model and
// two extra instances at other access-window lengths.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus4 ();

  mem_port_arbiter #(.MEM_BYTES(128), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  mem_port_arbiter #(.MEM_BYTES(128), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_port_arbiter #(.MEM_BYTES(128), .ACCESS_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  // Extra instances: IF reads only, memory returns the inverted address
  logic        sw_req1, sw_req4;
  logic [31:0] sw_addr;
  assign bus1.if_req    = sw_req1;
  assign bus1.if_addr   = sw_addr;
  assign bus1.dp_req    = 1'b0;
  assign bus1.dp_we     = 1'b0;
  assign bus1.dp_addr   = 32'd0;
  assign bus1.dp_wdata  = 32'd0;
  assign bus1.mem_rdata = ~bus1.mem_addr;
  assign bus4.if_req    = sw_req4;
  assign bus4.if_addr   = sw_addr;
  assign bus4.dp_req    = 1'b0;
  assign bus4.dp_we     = 1'b0;
  assign bus4.dp_addr   = 32'd0;
  assign bus4.dp_wdata  = 32'd0;
  assign bus4.mem_rdata = ~bus4.mem_addr;

  // Big-endian byte memory model for the main instance
  logic [7:0] mem [0:127];
  always_comb begin
    bus.mem_rdata = 32'd0;
    if (bus.mem_rd && bus.mem_addr <= 32'd124)
      bus.mem_rdata = {mem[bus.mem_addr[6:0]],        mem[bus.mem_addr[6:0] + 7'd1],
                       mem[bus.mem_addr[6:0] + 7'd2], mem[bus.mem_addr[6:0] + 7'd3]};
  end
  always @(posedge clk) begin
    if (bus.mem_wr && bus.mem_addr <= 32'd124) begin
      mem[bus.mem_addr[6:0]]        <= bus.mem_wdata[31:24];
      mem[bus.mem_addr[6:0] + 7'd1] <= bus.mem_wdata[23:16];
      mem[bus.mem_addr[6:0] + 7'd2] <= bus.mem_wdata[15:8];
      mem[bus.mem_addr[6:0] + 7'd3] <= bus.mem_wdata[7:0];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        dp;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // Monitor: strobe accounting and scoreboard compare on every ack
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd) rd_cnt++;
      if (bus.mem_wr) wr_cnt++;
      if (bus.mem_rd || bus.mem_wr) begin
        check("strobe_excl", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
        check("strobe_addr_legal",
              32'(bus.mem_addr <= 32'd124 && bus.mem_addr[1:0] == 2'b00), 32'd1);
      end
      if (bus.if_ack || bus.dp_ack) begin
        check("ack_onehot", 32'(bus.if_ack & bus.dp_ack), 32'd0);
        if (sb.size() == 0) begin
          check("ack_unexpected", 32'(bus.if_ack | bus.dp_ack), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_port", 32'(bus.dp_ack), 32'(e.dp));
          check("ack_err", 32'(bus.err), 32'(e.err));
          check("ack_rdata", e.dp ? bus.dp_rdata : bus.if_rdata, e.data);
        end
      end
    end
  end

  // One request on one port; checks ack latency and strobe counts
  task automatic do_req(input string tag, input bit dp, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit exp_err, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_rd, input int exp_wr);
    int   n;
    int   rd0, wr0;
    logic acked;
    sb.push_back('{dp, exp_err, exp_data});
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    if (dp) begin
      bus.dp_req = 1'b1; bus.dp_we = we; bus.dp_addr = addr; bus.dp_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    n = 0;
    acked = 1'b0;
    while (!acked && n < 20) begin
      @(negedge clk);
      n++;
      acked = dp ? bus.dp_ack : bus.if_ack;
    end
    bus.if_req = 1'b0;
    bus.dp_req = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  // Both ports request together and stay asserted until n_acks acks seen
  task automatic run_both(input int n_acks, output int acks, output int t_dp, output int t_if);
    int n;
    n = 0; acks = 0; t_dp = -1; t_if = -1;
    bus.dp_req = 1'b1;
    bus.if_req = 1'b1;
    while (acks < n_acks && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.dp_ack) begin acks++; if (t_dp < 0) t_dp = n; end
      if (bus.if_ack) begin acks++; if (t_if < 0) t_if = n; end
    end
    bus.dp_req = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks, t_dp, t_if, n, lat1, lat4, r1, r4;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.dp_req = 1'b0; bus.dp_we = 1'b0; bus.dp_addr = 32'd0; bus.dp_wdata = 32'd0;
    sw_req1 = 1'b0; sw_req4 = 1'b0; sw_addr = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_acks_err", 32'({bus.if_ack, bus.dp_ack, bus.err}), 32'd0);
    check("rst_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_dp_rdata", bus.dp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legal accesses and rejections
    do_req("if_rd0",     1'b0, 1'b0, 32'h00,       32'h0,        1'b0, 32'h12345678, 3, 2, 0);
    do_req("dp_st40",    1'b1, 1'b1, 32'h40,       32'hDEADBEEF, 1'b0, 32'h00000000, 3, 0, 2);
    do_req("dp_ld40",    1'b1, 1'b0, 32'h40,       32'h0,        1'b0, 32'hDEADBEEF, 3, 2, 0);
    do_req("dp_ld42",    1'b1, 1'b0, 32'h42,       32'h0,        1'b1, 32'hDEADBEEF, 1, 0, 0);
    do_req("dp_st42",    1'b1, 1'b1, 32'h42,       32'h11111111, 1'b1, 32'hDEADBEEF, 1, 0, 0);
    do_req("if_rd7d",    1'b0, 1'b0, 32'h7D,       32'h0,        1'b1, 32'h12345678, 1, 0, 0);
    do_req("if_rd7c",    1'b0, 1'b0, 32'h7C,       32'h0,        1'b0, 32'h7C7D7E7F, 3, 2, 0);
    do_req("dp_st_wrap", 1'b1, 1'b1, 32'hFFFFFFFC, 32'h22222222, 1'b1, 32'hDEADBEEF, 1, 0, 0);
    do_req("if_rd80",    1'b0, 1'b0, 32'h80,       32'h0,        1'b1, 32'h7C7D7E7F, 1, 0, 0);
    do_req("dp_ld40b",   1'b1, 1'b0, 32'h40,       32'h0,        1'b0, 32'hDEADBEEF, 3, 2, 0);

    // Contention straight out of reset: DP, IF, DP, IF
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.dp_we = 1'b0; bus.dp_addr = 32'h40; bus.if_addr = 32'h00;
    sb.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    sb.push_back('{1'b0, 1'b0, 32'h12345678});
    sb.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    sb.push_back('{1'b0, 1'b0, 32'h12345678});
    run_both(4, acks, t_dp, t_if);
    check("tie_ack_count", 32'(acks), 32'd4);
    check("tie_dp_first_lat", 32'(t_dp), 32'd3);
    check("tie_if_gap", 32'(t_if - t_dp), 32'd4);

    // Reset in the middle of a store window
    bus.dp_req = 1'b1; bus.dp_we = 1'b1; bus.dp_addr = 32'h10; bus.dp_wdata = 32'h55AA55AA;
    @(negedge clk);
    check("mid_wr_high", 32'(bus.mem_wr), 32'd1);
    bus.dp_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_wr_drop", 32'(bus.mem_wr), 32'd0);
    check("mid_no_ack", 32'({bus.if_ack, bus.dp_ack}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.dp_we = 1'b0; bus.dp_addr = 32'h10; bus.if_addr = 32'h04;
    sb.push_back('{1'b1, 1'b0, 32'h10111213});
    sb.push_back('{1'b0, 1'b0, 32'h04050607});
    run_both(2, acks, t_dp, t_if);
    check("post_rst_ack_count", 32'(acks), 32'd2);
    check("post_rst_dp_first", 32'(t_dp), 32'd3);
    check("post_rst_if_next", 32'(t_if), 32'd7);

    // Access-window length 1 and 4
    sw_addr = 32'h08; sw_req1 = 1'b1; sw_req4 = 1'b1;
    n = 0; lat1 = 0; lat4 = 0; r1 = 0; r4 = 0;
    while ((lat1 == 0 || lat4 == 0) && n < 20) begin
      @(negedge clk);
      n++;
      if (bus1.mem_rd) r1++;
      if (bus4.mem_rd) r4++;
      if (bus1.if_ack && lat1 == 0) begin lat1 = n; sw_req1 = 1'b0; end
      if (bus4.if_ack && lat4 == 0) begin lat4 = n; sw_req4 = 1'b0; end
    end
    sw_req1 = 1'b0; sw_req4 = 1'b0;
    check("ac1_latency", 32'(lat1), 32'd2);
    check("ac4_latency", 32'(lat4), 32'd5);
    check("ac1_strobe_width", 32'(r1), 32'd1);
    check("ac4_strobe_width", 32'(r4), 32'd4);
    check("ac1_rdata", bus1.if_rdata, 32'hFFFFFFF7);
    check("ac4_rdata", bus4.if_rdata, 32'hFFFFFFF7);
    check("ac1_err", 32'(bus1.err), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
